// File: rtl/fwd_ctrl_if.sv
// Operand-forwarding control bus between the pipeline (master) and fwd_ctrl (slave).
interface fwd_ctrl_if #(
  parameter int RF_ADDR_W   = 5,
  parameter int STALL_CNT_W = 16
);
  logic [RF_ADDR_W-1:0]   ex_rs1;
  logic [RF_ADDR_W-1:0]   ex_rs2;
  logic                   ex_use_rs1;
  logic                   ex_use_rs2;
  logic [RF_ADDR_W-1:0]   mem_rd;
  logic                   mem_we;
  logic                   mem_is_load;
  logic [RF_ADDR_W-1:0]   wb_rd;
  logic                   wb_we;
  logic                   wb_is_load;
  logic                   stall_in;
  logic [2:0]             fwd_sel1;
  logic [2:0]             fwd_sel2;
  logic                   hazard_stall;
  logic                   temp_capture;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2,
    output mem_rd, mem_we, mem_is_load,
    output wb_rd, wb_we, wb_is_load, stall_in,
    input  fwd_sel1, fwd_sel2, hazard_stall, temp_capture, stall_cnt
  );

  modport slave (
    input  ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2,
    input  mem_rd, mem_we, mem_is_load,
    input  wb_rd, wb_we, wb_is_load, stall_in,
    output fwd_sel1, fwd_sel2, hazard_stall, temp_capture, stall_cnt
  );
endinterface

// File: rtl/fwd_ctrl.sv
// EX operand-forwarding select, load-use stall, WB temp slot and stall counter.
// Optional temp slot enabled by macro FWD_TEMP_EN; selects and stall are combinational.
module fwd_ctrl #(
  parameter int RF_ADDR_W   = 5,
  parameter int STALL_CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  fwd_ctrl_if.slave  bus
);

  function automatic logic [2:0] pick_sel(input logic mem_hit, input logic mem_ld,
                                          input logic wb_hit,  input logic wb_ld,
                                          input logic tmp_hit, input logic tmp_ld);
    logic [2:0] s;
    s = 3'd0;
    if (mem_hit)      s = mem_ld ? 3'd0 : 3'd1;
    else if (wb_hit)  s = wb_ld  ? 3'd3 : 3'd2;
    else if (tmp_hit) s = tmp_ld ? 3'd4 : 3'd5;
    return s;
  endfunction

  logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic tmp_hit1, tmp_hit2, tmp_ld;
  logic hazard, wb_writes, capture;
  logic [STALL_CNT_W-1:0] cnt_q;

  assign mem_hit1 = bus.ex_use_rs1 && bus.mem_we && (bus.mem_rd != '0) && (bus.mem_rd == bus.ex_rs1);
  assign mem_hit2 = bus.ex_use_rs2 && bus.mem_we && (bus.mem_rd != '0) && (bus.mem_rd == bus.ex_rs2);
  assign wb_hit1  = bus.ex_use_rs1 && bus.wb_we  && (bus.wb_rd  != '0) && (bus.wb_rd  == bus.ex_rs1);
  assign wb_hit2  = bus.ex_use_rs2 && bus.wb_we  && (bus.wb_rd  != '0) && (bus.wb_rd  == bus.ex_rs2);

  assign hazard    = bus.mem_is_load && (mem_hit1 || mem_hit2);
  assign wb_writes = bus.wb_we && (bus.wb_rd != '0);

`ifdef FWD_TEMP_EN
  logic                 temp_valid;
  logic [RF_ADDR_W-1:0] temp_rd;
  logic                 temp_is_load;

  // temp_rd is never x0 when valid, so no zero check is needed here
  assign tmp_hit1 = bus.ex_use_rs1 && temp_valid && (temp_rd == bus.ex_rs1);
  assign tmp_hit2 = bus.ex_use_rs2 && temp_valid && (temp_rd == bus.ex_rs2);
  assign tmp_ld   = temp_is_load;
  assign capture  = hazard && !bus.stall_in && wb_writes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp_valid   <= 1'b0;
      temp_rd      <= '0;
      temp_is_load <= 1'b0;
    end else if (!bus.stall_in) begin
      if (capture) begin
        temp_valid   <= 1'b1;
        temp_rd      <= bus.wb_rd;
        temp_is_load <= bus.wb_is_load;
      end else if (!hazard) begin
        temp_valid   <= 1'b0;
      end
    end
  end
`else
  // Without the slot the retiring WB value is read back through the register file.
  assign tmp_hit1 = 1'b0;
  assign tmp_hit2 = 1'b0;
  assign tmp_ld   = 1'b0;
  assign capture  = 1'b0;
  logic unused_ok;
  assign unused_ok = wb_writes;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (hazard && !bus.stall_in && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.fwd_sel1     = rst ? 3'd0 : pick_sel(mem_hit1, bus.mem_is_load, wb_hit1, bus.wb_is_load, tmp_hit1, tmp_ld);
  assign bus.fwd_sel2     = rst ? 3'd0 : pick_sel(mem_hit2, bus.mem_is_load, wb_hit2, bus.wb_is_load, tmp_hit2, tmp_ld);
  assign bus.hazard_stall = !rst && hazard;
  assign bus.temp_capture = !rst && capture;
  assign bus.stall_cnt    = cnt_q;

endmodule
